// File: rtl/bcd_countdown_timer.sv
// 3-digit BCD countdown timer (tens.ones.tenths) driven by a 100 ms tick.
// Optional warning output with 500 ms blink is built when COUNTDOWN_WARN_EN is defined.
module bcd_countdown_timer #(
    parameter logic [11:0] DEFAULT_LOAD = 12'h300,
    parameter logic [11:0] WARN_THRESH  = 12'h050
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_in,
    input  logic        load,
    input  logic        load_default,
    input  logic [11:0] load_value,
    input  logic        start,
    input  logic        pause,
    output logic [11:0] bcd_out,
    output logic        running,
    output logic        expired,
    output logic        timeout_pulse,
    output logic        warn
);

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned BCD_W   = 3 * DIGIT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_EXPIRED
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               w_pulse_nxt;
    logic               w_warn_nxt;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_W'(9)) ? DIGIT_W'(9) : d;
    endfunction

    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v);
        return {clamp_digit(v[11:8]), clamp_digit(v[7:4]), clamp_digit(v[3:0])};
    endfunction

    // Subtract one tenth with BCD borrow; caller guarantees v != 0.
    function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] v);
        logic [DIGIT_W-1:0] h, o, t;
        {h, o, t} = v;
        if (t != '0) begin
            t = t - DIGIT_W'(1);
        end else begin
            t = DIGIT_W'(9);
            if (o != '0) begin
                o = o - DIGIT_W'(1);
            end else begin
                o = DIGIT_W'(9);
                h = h - DIGIT_W'(1);
            end
        end
        return {h, o, t};
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = bcd_out;
        w_pulse_nxt = 1'b0;
        if (load) begin
            w_bcd_nxt   = clamp_bcd(load_value);
            w_state_nxt = ST_IDLE;
        end else if (load_default) begin
            w_bcd_nxt   = clamp_bcd(DEFAULT_LOAD);
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (bcd_out != '0) begin
                            w_state_nxt = ST_RUN;
                        end else begin
                            w_state_nxt = ST_EXPIRED;
                            w_pulse_nxt = 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (tick_in && (bcd_out != '0)) begin
                        w_bcd_nxt = bcd_dec(bcd_out);
                        if (bcd_out == BCD_W'(1)) begin
                            w_state_nxt = ST_EXPIRED;
                            w_pulse_nxt = 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!pause && start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_EXPIRED: begin
                    w_bcd_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

`ifdef COUNTDOWN_WARN_EN
    localparam int unsigned BLINK_W    = 3;
    localparam int unsigned BLINK_LAST = 4;

    logic [BLINK_W-1:0] r_blink_cnt;
    logic [BLINK_W-1:0] w_blink_cnt_nxt;
    logic               r_blink_on;
    logic               w_blink_on_nxt;
    logic               w_restart;
    logic               w_resume;
    logic               w_tick_run;

    // Blink phase only advances on ticks taken while already at or below the threshold,
    // so the first toggle lands five ticks after warn first asserts.
    always_comb begin
        w_restart  = load || load_default || ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN));
        w_resume   = (r_state == ST_PAUSE) && (w_state_nxt == ST_RUN);
        w_tick_run = (r_state == ST_RUN) && !load && !load_default && !pause && tick_in;
        w_blink_cnt_nxt = r_blink_cnt;
        w_blink_on_nxt  = r_blink_on;
        if (w_restart) begin
            w_blink_cnt_nxt = '0;
            w_blink_on_nxt  = 1'b1;
        end else if (w_resume) begin
            w_blink_cnt_nxt = '0;
        end else if (w_tick_run && (bcd_out <= WARN_THRESH)) begin
            if (r_blink_cnt == BLINK_W'(BLINK_LAST)) begin
                w_blink_cnt_nxt = '0;
                w_blink_on_nxt  = ~r_blink_on;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + BLINK_W'(1);
            end
        end
        w_warn_nxt = ((w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE))
                     && (w_bcd_nxt <= WARN_THRESH) && w_blink_on_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_blink_on  <= w_blink_on_nxt;
        end
    end
`else
    // Constant 0; the threshold is referenced so both builds keep one parameter list.
    assign w_warn_nxt = &{1'b0, WARN_THRESH};
`endif

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            bcd_out       <= DEFAULT_LOAD;
            running       <= 1'b0;
            expired       <= 1'b0;
            timeout_pulse <= 1'b0;
            warn          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            bcd_out       <= w_bcd_nxt;
            running       <= (w_state_nxt == ST_RUN);
            expired       <= (w_state_nxt == ST_EXPIRED);
            timeout_pulse <= w_pulse_nxt;
            warn          <= w_warn_nxt;
        end
    end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Consumes the single-cycle 100 ms tick from the tick-divider chain and counts a 3-digit BCD value (tens of seconds, seconds, tenths) down to zero.
- The BCD math game uses it as the per-question answer timer; its outputs drive the seven-segment display path and the game controller.
- Emits a one-cycle timeout pulse and a sticky expired flag when the count reaches 0.0.

Parameters:
- DEFAULT_LOAD, 12'h300, BCD value used when load_default is asserted (30.0 s).
- WARN_THRESH, 12'h050, BCD threshold for the warning output, used only under the optional feature (5.0 s).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick_in  in  1  one-cycle 100 ms tick pulse
- load  in  1  load load_value and enter IDLE
- load_default  in  1  load DEFAULT_LOAD and enter IDLE
- load_value  in  12  BCD load value {tens, ones, tenths}
- start  in  1  begin or resume counting
- pause  in  1  suspend counting
- bcd_out  out  12  current remaining time, BCD
- running  out  1  high while in RUN
- expired  out  1  sticky; high in EXPIRED
- timeout_pulse  out  1  one-cycle pulse on reaching 0.0
- warn  out  1  warning; only under the optional feature, else tied 0

Behaviour:
- All outputs are registered and update on posedge clk.
- Reset (reset==0, sampled on clk): state=IDLE, bcd_out=DEFAULT_LOAD, running=0, expired=0, timeout_pulse=0, warn=0.
- States: IDLE, RUN, PAUSE, EXPIRED.
- Input priority within a cycle: reset > load > load_default > pause > start > tick_in.
- load or load_default in any state:
  - bcd_out takes the new value next cycle; state=IDLE; expired=0.
  - Each loaded digit >9 is clamped to 9 (e.g. 12'h3AF loads as 12'h399).
  - load wins over load_default when both are asserted.
- IDLE:
  - start with bcd_out!=0 -> RUN.
  - start with bcd_out==0 -> EXPIRED, with timeout_pulse=1 for that one cycle.
- RUN:
  - pause -> PAUSE; a tick in the same cycle is ignored.
  - tick_in decrements by one tenth; the new value is visible the cycle after the tick.
  - BCD borrow rules:
    - tenths 0 -> 9, borrow from ones;
    - ones 0 -> 9, borrow from tens;
    - tens never underflows, because 0.0 ends the count.
  - A tick at 0.1 gives bcd_out=0.0, state=EXPIRED and timeout_pulse=1, all on the same edge.
- PAUSE:
  - Ticks are ignored.
  - start -> RUN.
  - pause and start together: pause wins, state stays PAUSE.
- EXPIRED:
  - bcd_out holds 0.0 and expired=1.
  - start and tick_in are ignored.
  - Only load, load_default or reset leave this state.
- running=1 exactly when state==RUN.
- timeout_pulse is never high two cycles in a row.
- tick_in wider than one cycle is not supported: each high cycle counts as one tick.
- Reset mid-count aborts at once; there is no pending timeout pulse afterwards.

Optional Feature:
- Macro: COUNTDOWN_WARN_EN.
- When defined:
  - warn=1 while state is RUN or PAUSE and bcd_out <= WARN_THRESH (BCD compare, digit-wise from most significant).
  - In RUN, warn toggles on every 5th tick_in (a 500 ms blink) via a 3-bit tick counter. The counter clears on entry to RUN and on load.
  - warn=0 in IDLE and EXPIRED.
- When undefined: warn is constant 0 and no compare or blink logic is built.

Test Plan:
- Reset low for 2 cycles, then high -> bcd_out=12'h300, running=0, expired=0, timeout_pulse=0.
- load_value=12'h012, load, start, then 12 ticks 10 cycles apart:
  - bcd_out steps 011, 010, 009, ..., 001, 000;
  - timeout_pulse is high for exactly 1 cycle on the 12th tick;
  - expired=1 and running=0 afterwards.
- Borrow chain: load 12'h100, start, 1 tick -> bcd_out=12'h099.
- Load 12'hFFF -> bcd_out=12'h999.
- Pause handling, from load 12'h050 and start:
  - 3 ticks -> 047;
  - pause plus 5 ticks -> 047 is held and running=0;
  - start plus 2 ticks -> 045.
- Zero load: load 12'h000 then start -> EXPIRED next cycle, timeout_pulse=1 for one cycle.
- In EXPIRED, start plus ticks leave bcd_out at 0; load_default -> 12'h300 and expired=0.
- With COUNTDOWN_WARN_EN defined, load 12'h052 and start:
  - warn=0 until bcd_out=050;
  - warn=1 at 050;
  - warn then toggles every 5 ticks;
  - warn=0 in EXPIRED.
